// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter width
// and the state-to-reset-output decode.
package reset_seq_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_PERIPH = 2'd1,
    S_CORE   = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  typedef struct packed {
    logic periph_n;
    logic core_n;
    logic app_n;
    logic ready;
  } rst_out_t;

  // Release set only grows from S_ASSERT to S_RUN, so ordering holds by construction.
  function automatic rst_out_t decode_outputs(state_t s);
    rst_out_t o;
    o.periph_n = (s != S_ASSERT);
    o.core_n   = (s == S_CORE) || (s == S_RUN);
    o.app_n    = (s == S_RUN);
    o.ready    = (s == S_RUN);
    return o;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c,
                                               logic [CNT_W-1:0] last);
    return (c < last) ? c + CNT_W'(1) : c;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output follows the
// synchronized input only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // A sample matching the current level restarts the stability count.
      if (sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        btn_db <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= sat_inc(db_cnt, DB_LAST);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: periph, then core, then app, restarted by power-on
// reset or a debounced pushbutton press. All outputs are registered.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_CYCLES    = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_reset,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       rst_app_n,
  output logic       sys_ready,
  output logic [1:0] state_dbg
);

  // The output register adds one cycle, so each state is left one count
  // early to keep output edges at HOLD, HOLD+STAGE, HOLD+2*STAGE.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

  logic             btn_db;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  rst_out_t         out_q;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .btn_raw(btn_reset),
    .btn_db (btn_db)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_ASSERT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    // A held button wins over any counter expiry in the same cycle.
    if (btn_db) begin
      state_n = S_ASSERT;
      cnt_n   = '0;
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt >= HOLD_LAST) begin
            state_n = S_PERIPH;
            cnt_n   = '0;
          end else begin
            cnt_n = sat_inc(cnt, HOLD_LAST);
          end
        end
        S_PERIPH: begin
          if (cnt >= STAGE_LAST) begin
            state_n = S_CORE;
            cnt_n   = '0;
          end else begin
            cnt_n = sat_inc(cnt, STAGE_LAST);
          end
        end
        S_CORE: begin
          if (cnt >= STAGE_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = sat_inc(cnt, STAGE_LAST);
          end
        end
        S_RUN: begin
          cnt_n = '0;
        end
        default: begin
          state_n = S_ASSERT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else begin
      out_q <= decode_outputs(state);
    end
  end

  assign rst_periph_n = out_q.periph_n;
  assign rst_core_n   = out_q.core_n;
  assign rst_app_n    = out_q.app_n;
  assign sys_ready    = out_q.ready;
  assign state_dbg    = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: per-cycle comparison against a timing model built
// from release delays and a sliding-window debounce, plus fixed-cycle checks.
module tb_reset_sequencer;

  localparam int H = 4;
  localparam int S = 8;
  localparam int D = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_reset = 1'b0;
  logic       rst_periph_n;
  logic       rst_core_n;
  logic       rst_app_n;
  logic       sys_ready;
  logic [1:0] state_dbg;
  logic [3:0] act;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: run_len = consecutive edges that saw the debounced button low.
  int         run_len = 0;
  logic       db_m = 1'b0;
  logic       raw_hist[$];
  logic       q_win[$];
  logic [3:0] exp_out = '0;

  reset_sequencer #(
    .HOLD_CYCLES    (H),
    .STAGE_CYCLES   (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_reset   (btn_reset),
    .rst_periph_n(rst_periph_n),
    .rst_core_n  (rst_core_n),
    .rst_app_n   (rst_app_n),
    .sys_ready   (sys_ready),
    .state_dbg   (state_dbg)
  );

  assign act = {rst_periph_n, rst_core_n, rst_app_n, sys_ready};

  always #5 clock = ~clock;

  task automatic model_clear();
    run_len = 0;
    db_m    = 1'b0;
    raw_hist.delete();
    q_win.delete();
    exp_out = '0;
  endtask

  // Drive one button level for one clock edge, advance the model, return at negedge.
  task automatic tick(input logic b);
    logic q;
    logic same;
    btn_reset = b;
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      model_clear();
    end else begin
      exp_out = {run_len >= H, run_len >= H + S, run_len >= H + 2*S, run_len >= H + 2*S};
      if (db_m) run_len = 0;
      else if (run_len < 100000) run_len++;
      raw_hist.push_back(b);
      q = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : 1'b0;
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
      q_win.push_back(q);
      if (q_win.size() > D) void'(q_win.pop_front());
      if (q_win.size() == D) begin
        same = 1'b1;
        foreach (q_win[i]) if (q_win[i] !== q) same = 1'b0;
        if (same) db_m = q;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (act !== 4'b0000) begin
      bad++;
      $display("FAIL reset_time0 got=%b want=0000", act);
    end
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      total++;
      if (act !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", cyc, act);
      end
    end
  endtask

  task automatic test_power_on();
    int rp, rc, ra;
    rp = -1; rc = -1; ra = -1;
    reset_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      tick(1'b0);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL power_on cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
      if (rp < 0 && rst_periph_n) rp = n;
      if (rc < 0 && rst_core_n) rc = n;
      if (ra < 0 && rst_app_n && sys_ready) ra = n;
    end
    total++;
    if (rp != 4 || rc != 12 || ra != 20) begin
      bad++;
      $display("FAIL power_on_edges got=%0d/%0d/%0d want=4/12/20", rp, rc, ra);
    end
  endtask

  task automatic test_short_press();
    logic dropped;
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 3);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL short_press cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
      if (act !== 4'b1111) dropped = 1'b1;
    end
    total++;
    if (dropped) begin
      bad++;
      $display("FAIL short_press_glitch got=dropped want=steady");
    end
  endtask

  task automatic test_long_press();
    int rp, rc, ra;
    rp = -1; rc = -1; ra = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL long_press cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
      if (i == 9) begin
        total++;
        if (act !== 4'b0000) begin
          bad++;
          $display("FAIL long_press_low_by_9 got=%b want=0000", act);
        end
      end
    end
    for (int i = 0; i < 35; i++) begin
      tick(1'b0);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL long_release cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
      if (rp < 0 && rst_periph_n) rp = i;
      if (rc < 0 && rst_core_n) rc = i;
      if (ra < 0 && rst_app_n) ra = i;
    end
    total++;
    if (rp != 11 || rc != 19 || ra != 27) begin
      bad++;
      $display("FAIL long_release_edges got=%0d/%0d/%0d want=11/19/27", rp, rc, ra);
    end
  endtask

  task automatic test_reset_mid_core();
    int rp, rc, ra;
    rp = -1; rc = -1; ra = -1;
    reset_n = 1'b0;
    model_clear();
    tick(1'b0);
    tick(1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL pre_core cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
    end
    total++;
    if (act !== 4'b1100) begin
      bad++;
      $display("FAIL in_core got=%b want=1100", act);
    end
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (act !== 4'b0000) begin
      bad++;
      $display("FAIL async_abort got=%b want=0000", act);
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) tick(1'b0);
    reset_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      tick(1'b0);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL restart cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
      if (rp < 0 && rst_periph_n) rp = n;
      if (rc < 0 && rst_core_n) rc = n;
      if (ra < 0 && rst_app_n) ra = n;
    end
    total++;
    if (rp != 4 || rc != 12 || ra != 20) begin
      bad++;
      $display("FAIL restart_edges got=%0d/%0d/%0d want=4/12/20", rp, rc, ra);
    end
  endtask

  task automatic test_bounce();
    int rp;
    rp = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL bounce_press cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(((i / 2) % 2) == 1);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL bounce_toggle cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
    end
    for (int i = 0; i < 35; i++) begin
      tick(1'b0);
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL bounce_settle cyc=%0d got=%b want=%b", cyc, act, exp_out);
      end
      if (rp < 0 && rst_periph_n) rp = i;
    end
    total++;
    if (rp != 11) begin
      bad++;
      $display("FAIL bounce_periph_edge got=%0d want=11", rp);
    end
  endtask

  task automatic test_random();
    int   len;
    logic b;
    for (int r = 0; r < 60; r++) begin
      b   = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 15) == 0) begin
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (act !== 4'b0000) begin
          bad++;
          $display("FAIL rand_async cyc=%0d got=%b want=0000", cyc, act);
        end
        @(negedge clock);
        tick(1'b0);
        reset_n = 1'b1;
      end
      for (int k = 0; k < len; k++) begin
        tick(b);
        total++;
        if (act !== exp_out) begin
          bad++;
          $display("FAIL random cyc=%0d got=%b want=%b", cyc, act, exp_out);
        end
        total++;
        if ((rst_core_n && !rst_periph_n) || (rst_app_n && !rst_core_n) ||
            (sys_ready !== rst_app_n)) begin
          bad++;
          $display("FAIL order cyc=%0d got=%b want=monotonic", cyc, act);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_power_on();
    test_short_press();
    test_long_press();
    test_reset_mid_core();
    test_bounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles all domain resets stay asserted after the sequence starts; range 1..2^20-1.
REQ-002 Parameter STAGE_CYCLES, default 100: cycles between successive domain releases; range 1..2^20-1.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable-level cycles needed to accept a button change (10 ms at 100 MHz); range 1..2^20-1.
REQ-004 clock  input  1  single 100 MHz system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low; driven by the power-on reset generator.
REQ-006 btn_reset  input  1  raw board pushbutton, active-high, asynchronous to clock, bouncy.
REQ-007 rst_periph_n  output  1  active-low reset for I/O peripherals, released first.
REQ-008 rst_core_n  output  1  active-low reset for core datapath, released second.
REQ-009 rst_app_n  output  1  active-low reset for application logic, released last.
REQ-010 sys_ready  output  1  high only when all three domain resets are released.

Function
REQ-011 btn_reset SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounced level btn_db SHALL change only after the synchronized button has held the new level for DEBOUNCE_CYCLES consecutive cycles; any differing sample restarts the count.
REQ-013 FSM states: S_ASSERT, S_PERIPH, S_CORE, S_RUN; one 20-bit cycle counter, cleared on every state entry.
REQ-014 S_ASSERT: all three resets low, sys_ready low; while btn_db high remain here with counter held at 0; exit to S_PERIPH when counter reaches HOLD_CYCLES with btn_db low.
REQ-015 S_PERIPH: rst_periph_n high, others low; exit to S_CORE after STAGE_CYCLES cycles.
REQ-016 S_CORE: rst_periph_n and rst_core_n high, rst_app_n low; exit to S_RUN after STAGE_CYCLES cycles.
REQ-017 S_RUN: all resets high, sys_ready high; stay until button or reset.
REQ-018 All outputs SHALL be registered, decoded from state; no combinational path from any input to any output.
REQ-019 Timing, cycle 0 = first rising edge with reset_n high (or first cycle btn_db low after a press): rst_periph_n rises at cycle HOLD_CYCLES, rst_core_n at HOLD_CYCLES+STAGE_CYCLES, rst_app_n and sys_ready at HOLD_CYCLES+2*STAGE_CYCLES.
REQ-020 btn_db high in any state SHALL force S_ASSERT on the next edge (all outputs low one cycle later), taking priority over any same-cycle counter-expiry transition.
REQ-021 A release SHALL never be reordered: rst_core_n high implies rst_periph_n high; rst_app_n high implies rst_core_n high.
REQ-022 Counter SHALL never wrap; it saturates at its terminal value for the current state.

Reset
REQ-023 reset_n low SHALL immediately (asynchronously) force: state S_ASSERT, counter 0, rst_periph_n/rst_core_n/rst_app_n 0, sys_ready 0, synchronizer flops 0, btn_db 0, debounce counter 0.
REQ-024 reset_n asserted mid-sequence SHALL abort it; release restarts the full timing of REQ-019.

Structure
REQ-025 Shared package reset_seq_pkg SHALL hold the state encodings and the counter width constant (20).
REQ-026 Synchronizer plus debounce SHALL be a sub-module named debounce, parameterized by DEBOUNCE_CYCLES, same clock/reset ports.

Verification (HOLD_CYCLES=4, STAGE_CYCLES=8, DEBOUNCE_CYCLES=5)
REQ-027 reset_n low 10 cycles then high, button idle -> rst_periph_n rises at cycle 4, rst_core_n at 12, rst_app_n and sys_ready at 20.
REQ-028 In S_RUN, btn_reset high for 3 cycles -> no output change.
REQ-029 In S_RUN, btn_reset high 30 cycles -> all outputs low by cycle 2+5+2 after press, stay low while held; after release, rises follow at +4/+12/+20 from btn_db falling.
REQ-030 reset_n pulsed low during S_CORE -> all outputs low in the same cycle (without waiting for a clock edge); after release, full 4/12/20 sequence.
REQ-031 Release bounce: button toggles every 2 cycles for 12 cycles then low -> btn_db falls only 5 stable cycles after last toggle; sequence timed from that point.
